transmit_link_output_buffer: RTL and testbench

//  Per-link store-and-forward packet FIFO that sits directly downstream of input_link_router on its transmit lane.

---
 rtl/transmit_link_output_buffer.sv | 125 ++++++++++++
 tb/tb_transmit_link_output_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/transmit_link_output_buffer.sv
// Store-and-forward packet FIFO between input_link_router and one transmit link.
// Holds whole packets until their last word arrives, with forced cut-through when the store fills.
module transmit_link_output_buffer #(
  parameter int LINK_NUMBER = 0,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic                  flush,
  output logic                  transmit_link_output_buffer_full,
  output logic [DATA_WIDTH-1:0] link_data,
  output logic                  link_valid,
  output logic                  link_last,
  input  logic                  link_ready,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic [ADDR_WIDTH:0]   packet_count,
  output logic                  overflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_C  = (ADDR_WIDTH+1)'(DEPTH - FULL_MARGIN);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

  if (FULL_MARGIN < 1 || FULL_MARGIN > DEPTH - 1 || LINK_NUMBER < 0) begin : g_param_check
    $error("transmit_link_output_buffer: FULL_MARGIN must be 1..DEPTH-1 and LINK_NUMBER >= 0");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   occ_next, pc_next;
  logic [DATA_WIDTH:0]   head;
  logic                  at_capacity, xfer, wr_en, drop, wr_last, rd_last;

  // Pointers carry one extra bit, so their difference spans 0..DEPTH without ambiguity.
  assign occupancy   = wr_ptr - rd_ptr;
  assign at_capacity = (occupancy == DEPTH_C);

  assign head      = mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign link_data = head[DATA_WIDTH-1:0];
  assign link_last = head[DATA_WIDTH];

  assign link_valid = (state_q == SEND) && (occupancy != '0);
  assign xfer       = link_valid && link_ready;

  // A transfer frees the head slot in the same cycle, so a full store can still accept a word.
  assign wr_en   = in_valid && (!at_capacity || xfer) && !flush;
  assign drop    = in_valid && at_capacity && !xfer;
  assign wr_last = wr_en && in_last;
  assign rd_last = xfer && link_last;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    occ_next = occupancy;
    pc_next  = packet_count;
    case ({wr_en, xfer})
      2'b10:   occ_next = occupancy + ONE_C;
      2'b01:   occ_next = occupancy - ONE_C;
      default: occ_next = occupancy;
    endcase
    case ({wr_last, rd_last})
      2'b10:   pc_next = packet_count + ONE_C;
      2'b01:   pc_next = packet_count - ONE_C;
      default: pc_next = packet_count;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // A store that fills with no complete packet must start sending or it deadlocks.
        if (packet_count != '0 || at_capacity) state_d = SEND;
      end
      SEND: begin
        if (rd_last && pc_next == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q                          <= IDLE;
      wr_ptr                           <= '0;
      rd_ptr                           <= '0;
      packet_count                     <= '0;
      overflow                         <= 1'b0;
      transmit_link_output_buffer_full <= 1'b0;
    end else if (flush) begin
      state_q                          <= IDLE;
      wr_ptr                           <= '0;
      rd_ptr                           <= '0;
      packet_count                     <= '0;
      overflow                         <= 1'b0;
      transmit_link_output_buffer_full <= 1'b0;
    end else begin
      state_q                          <= state_d;
      packet_count                     <= pc_next;
      transmit_link_output_buffer_full <= (occ_next >= FULL_C);
      if (wr_en) wr_ptr <= wr_ptr + ONE_C;
      if (xfer)  rd_ptr <= rd_ptr + ONE_C;
      if (drop)  overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; pointers define what is valid, so contents may be stale.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {in_last, in_data};
  end

endmodule

// File: tb/tb_transmit_link_output_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based packet model.
module tb_transmit_link_output_buffer;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int FM    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          flush = 1'b0;
  logic          link_ready = 1'b0;
  logic          tlob_full;
  logic [DW-1:0] link_data;
  logic          link_valid;
  logic          link_last;
  logic [AW:0]   occupancy;
  logic [AW:0]   packet_count;
  logic          overflow;

  always #5 clk = ~clk;

  transmit_link_output_buffer #(
    .LINK_NUMBER (0),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .FULL_MARGIN (FM)
  ) dut (
    .clk                              (clk),
    .rst_n                            (rst_n),
    .in_data                          (in_data),
    .in_valid                         (in_valid),
    .in_last                          (in_last),
    .flush                            (flush),
    .transmit_link_output_buffer_full (tlob_full),
    .link_data                        (link_data),
    .link_valid                       (link_valid),
    .link_last                        (link_last),
    .link_ready                       (link_ready),
    .occupancy                        (occupancy),
    .packet_count                     (packet_count),
    .overflow                         (overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: stored words as {last, data}, plus the sending flag and sticky/full flags.
  logic [DW:0] q[$];
  bit          sending = 1'b0;
  bit          m_ovf   = 1'b0;
  bit          m_full  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lasts_in_q();
    int n;
    n = 0;
    foreach (q[i]) if (q[i][DW]) n++;
    return n;
  endfunction

  task automatic model_reset();
    q.delete();
    sending = 1'b0;
    m_ovf   = 1'b0;
    m_full  = 1'b0;
  endtask

  task automatic compare_outputs();
    bit exp_valid;
    exp_valid = sending && (q.size() != 0);
    check("occupancy",    64'(occupancy),    64'(q.size()));
    check("packet_count", 64'(packet_count), 64'(lasts_in_q()));
    check("full",         64'(tlob_full),    64'(m_full));
    check("overflow",     64'(overflow),     64'(m_ovf));
    check("link_valid",   64'(link_valid),   64'(exp_valid));
    if (exp_valid) begin
      check("link_data", 64'(link_data), 64'(q[0][DW-1:0]));
      check("link_last", 64'(link_last), 64'(q[0][DW]));
    end
  endtask

  task automatic model_step();
    int          occ0;
    int          pc0;
    bit          xfer;
    logic [DW:0] popped;
    occ0   = q.size();
    pc0    = lasts_in_q();
    xfer   = sending && (occ0 != 0) && link_ready;
    popped = '0;
    if (flush) begin
      model_reset();
    end else begin
      if (xfer) popped = q.pop_front();
      if (in_valid) begin
        if (occ0 < DEPTH || xfer) q.push_back({in_last, in_data});
        else m_ovf = 1'b1;
      end
      m_full = (q.size() >= DEPTH - FM);
      if (!sending) sending = (pc0 != 0) || (occ0 == DEPTH);
      else if (xfer && popped[DW] && lasts_in_q() == 0) sending = 1'b0;
    end
  endtask

  // One clock: drive on the falling edge, compare before the rising edge, advance the model on it.
  task automatic cycle(input bit v, input bit l, input logic [DW-1:0] d, input bit rdy, input bit fl);
    @(negedge clk);
    in_valid   = v;
    in_last    = l;
    in_data    = d;
    link_ready = rdy;
    flush      = fl;
    #1 compare_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_flush();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_occ"},   64'(occupancy),    64'd0);
    check({tag, "_pkts"},  64'(packet_count), 64'd0);
    check({tag, "_ovf"},   64'(overflow),     64'd0);
    check({tag, "_full"},  64'(tlob_full),    64'd0);
    check({tag, "_valid"}, 64'(link_valid),   64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check_cleared("reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // 1: three-word packet, store-and-forward latency
    cycle(1'b1, 1'b0, 32'h0050ADFF, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'h00000001, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h02F8D309, 1'b1, 1'b0);
    check("t1_valid_n", 64'(link_valid), 64'd0);
    check("t1_pkts_n",  64'(packet_count), 64'd1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("t1_valid_n1", 64'(link_valid), 64'd1);
    check("t1_first",    64'(link_data),  64'h0050ADFF);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("t1_pkts_end",  64'(packet_count), 64'd0);
    check("t1_valid_end", 64'(link_valid),   64'd0);

    // 2: full threshold and drop on overflow
    do_flush();
    for (int k = 1; k <= 17; k++) begin
      cycle(1'b1, 1'b1, 32'(32'h200 + k), 1'b0, 1'b0);
      check("t2_occ",  64'(occupancy), 64'((k > DEPTH) ? DEPTH : k));
      check("t2_full", 64'(tlob_full), 64'(k >= DEPTH - FM));
      check("t2_ovf",  64'(overflow),  64'(k > DEPTH));
    end

    // 3: two 4-word packets stream back-to-back
    do_flush();
    for (int i = 0; i < 8; i++) cycle(1'b1, (i == 3 || i == 7), 32'(32'h300 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("t3_valid", 64'(link_valid), 64'd1);
      check("t3_data",  64'(link_data),  64'(32'h300 + i));
      check("t3_last",  64'(link_last),  64'(i == 3 || i == 7));
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    end
    check("t3_occ_end",   64'(occupancy),  64'd0);
    check("t3_valid_end", 64'(link_valid), 64'd0);

    // 4: simultaneous write and transfer at occupancy 16 and 1, across pointer wrap
    do_flush();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 32'(32'h400 + i), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b1, 32'(32'h500 + i), 1'b1, 1'b0);
      check("t4_occ16", 64'(occupancy), 64'd16);
      check("t4_ovf",   64'(overflow),  64'd0);
    end
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 32'(32'h580 + i), 1'b1, 1'b0);
      check("t4_occ1", 64'(occupancy), 64'd1);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // 5: oversize packet forces cut-through
    do_flush();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 32'(32'h600 + i), 1'b1, 1'b0);
    check("t5_occ16",   64'(occupancy),  64'd16);
    check("t5_idle",    64'(link_valid), 64'd0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("t5_cut",     64'(link_valid), 64'd1);
    cycle(1'b1, 1'b1, 32'h000006FF, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_cleared("t5_end");

    // 6: flush mid-packet with a write, then asynchronous reset mid-transfer
    do_flush();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'(32'h700 + i), 1'b0, 1'b0);
    check("t6_occ5", 64'(occupancy), 64'd5);
    cycle(1'b1, 1'b0, 32'h00000BAD, 1'b0, 1'b1);
    check_cleared("t6_flush");
    for (int i = 0; i < 6; i++) cycle(1'b1, (i == 5), 32'(32'h780 + i), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check_cleared("t6_async");
    model_reset();
    @(negedge clk);
    #1 compare_outputs();
    rst_n = 1'b1;

    // Random traffic with varying link throughput and rare flushes
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 500; i++) begin
        cycle($urandom_range(0, 3) != 0,
              $urandom_range(0, 3) == 0,
              32'($urandom),
              $urandom_range(0, 7) < (b + 2),
              $urandom_range(0, 199) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
